// File: rtl/mlp_vector_load_ctrl_if.sv
// Handshake and bus bundle between the vector-load sequencer and its
// surroundings: vector stream in, LRAM write / BRAM read / result strobes out.
interface mlp_vector_load_ctrl_if #(
    parameter int NROW_W = 10
);
    logic              i_start;
    logic [NROW_W-1:0] i_num_rows;
    logic [127:0]      i_vec_data;
    logic              i_vec_valid;
    logic              o_vec_ready;
    logic [63:0]       o_wrdata;
    logic [63:0]       o_bram_din2mlp_din;
    logic              o_first;
    logic              o_last;
    logic              o_pause;
    logic              o_bram_rden;
    logic [NROW_W:0]   o_bram_rdaddr;
    logic              o_read;
    logic              i_mlp_valid;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_num_rows, i_vec_data, i_vec_valid, i_mlp_valid,
        output o_vec_ready, o_wrdata, o_bram_din2mlp_din, o_first, o_last,
        output o_pause, o_bram_rden, o_bram_rdaddr, o_read, o_busy, o_done
    );

    modport slave (
        output i_start, i_num_rows, i_vec_data, i_vec_valid, i_mlp_valid,
        input  o_vec_ready, o_wrdata, o_bram_din2mlp_din, o_first, o_last,
        input  o_pause, o_bram_rden, o_bram_rdaddr, o_read, o_busy, o_done
    );
endinterface

// File: rtl/mlp_vector_load_ctrl.sv
// Sequencer in front of the MLP int8 cascade: loads the 2*M-word vector into
// LRAM, streams BRAM row reads with an aligned read strobe, counts results.
module mlp_vector_load_ctrl #(
    parameter int M        = 6,
    parameter int NROW_W   = 10,
    parameter int BRAM_LAT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mlp_vector_load_ctrl_if.master bus
);

    localparam int NW   = 2 * M;
    localparam int WC_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int WT_W = $clog2(M + 3);
    localparam logic [BRAM_LAT-1:0] TOP = BRAM_LAT'(1) << (BRAM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        COMPUTE,
        DRAIN
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [NROW_W-1:0]   r_q;
    logic [WC_W-1:0]     wc_q;
    logic [WT_W-1:0]     wt_q;
    logic [NROW_W:0]     addr_q;
    logic [NROW_W-1:0]   rc_q;
    logic [BRAM_LAT-1:0] pipe_q;
    logic [63:0]         wr_q;
    logic [63:0]         din_q;
    logic                first_q;
    logic                last_q;
    logic                pause_q;

    logic            accept;
    logic            word_end;
    logic            wait_end;
    logic            addr_end;
    logic            rc_full;
    logic            pend;
    logic [NROW_W:0] rd_last;
    logic            ready;
    logic            rden;
    logic            busy;
    logic            done;

    assign accept   = (state == LOAD) && bus.i_vec_valid;
    assign word_end = accept && (wc_q == WC_W'(NW - 1));
    assign wait_end = (state == WAIT) && (wt_q == WT_W'(M + 2));
    assign rd_last  = {r_q, 1'b0} - (NROW_W + 1)'(1);
    assign addr_end = (state == COMPUTE) && (addr_q == rd_last);
    assign rc_full  = (rc_q == r_q);
    // reads still in flight that have not yet reached o_read
    assign pend     = |(pipe_q & ~TOP);

    // next state and state-decoded outputs
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        rden     = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.i_start) state_nx = LOAD;
            end
            LOAD: begin
                ready = 1'b1;
                if (word_end) state_nx = WAIT;
            end
            WAIT: begin
                if (wait_end) state_nx = (r_q == '0) ? DRAIN : COMPUTE;
            end
            COMPUTE: begin
                rden = 1'b1;
                if (addr_end) state_nx = DRAIN;
            end
            DRAIN: begin
                if (rc_full && !pend) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // row count, word, wait, address and result counters
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_q    <= '0;
            wc_q   <= '0;
            wt_q   <= '0;
            addr_q <= '0;
            rc_q   <= '0;
        end else begin
            if (state == IDLE && bus.i_start) r_q <= bus.i_num_rows;
            if (accept) wc_q <= word_end ? '0 : wc_q + 1'b1;
            wt_q <= (state == WAIT) ? wt_q + 1'b1 : '0;
            if (state == COMPUTE) addr_q <= addr_end ? '0 : addr_q + 1'b1;
            else                  addr_q <= '0;
            if (state == COMPUTE || state == DRAIN) begin
                if (bus.i_mlp_valid && !rc_full) rc_q <= rc_q + 1'b1;
            end else begin
                rc_q <= '0;
            end
        end
    end

    // read strobe delay line matching BRAM read latency
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) pipe_q <= '0;
        else         pipe_q <= BRAM_LAT'({pipe_q, rden});
    end

    // LRAM write port: one register stage from accept to presentation
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_q    <= '0;
            din_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            pause_q <= 1'b1;
        end else if (accept) begin
            wr_q    <= bus.i_vec_data[63:0];
            din_q   <= bus.i_vec_data[127:64];
            first_q <= (wc_q == '0);
            last_q  <= (wc_q == WC_W'(NW - 1));
            pause_q <= 1'b0;
        end else begin
            first_q <= 1'b0;
            last_q  <= 1'b0;
            pause_q <= 1'b1;
        end
    end

    assign bus.o_vec_ready        = ready;
    assign bus.o_wrdata           = wr_q;
    assign bus.o_bram_din2mlp_din = din_q;
    assign bus.o_first            = first_q;
    assign bus.o_last             = last_q;
    assign bus.o_pause            = pause_q;
    assign bus.o_bram_rden        = rden;
    assign bus.o_bram_rdaddr      = addr_q;
    assign bus.o_read             = pipe_q[BRAM_LAT-1];
    assign bus.o_busy             = busy;
    assign bus.o_done             = done;

endmodule

// File: tb/tb_mlp_vector_load_ctrl.sv
// Randomized bench for mlp_vector_load_ctrl; expectations come from a
// transaction-level timeline model (accept times, compute window, result count).
module tb_mlp_vector_load_ctrl;

    localparam int M      = 6;
    localparam int NROW_W = 10;
    localparam int LAT    = 2;
    localparam int NW     = 2 * M;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_wr    = '0;
    logic [63:0] m_din   = '0;
    logic        m_pause = 1'b1;
    logic        m_first = 1'b0;
    logic        m_last  = 1'b0;

    mlp_vector_load_ctrl_if #(.NROW_W(NROW_W)) bus ();

    mlp_vector_load_ctrl #(
        .M(M),
        .NROW_W(NROW_W),
        .BRAM_LAT(LAT)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, "_pause"}, bus.o_pause, 1);
        chk({pfx, "_ready"}, bus.o_vec_ready, 0);
        chk({pfx, "_rden"}, bus.o_bram_rden, 0);
        chk({pfx, "_read"}, bus.o_read, 0);
        chk({pfx, "_busy"}, bus.o_busy, 0);
        chk({pfx, "_done"}, bus.o_done, 0);
        chk({pfx, "_first"}, bus.o_first, 0);
        chk({pfx, "_last"}, bus.o_last, 0);
        chk({pfx, "_addr"}, bus.o_bram_rdaddr, 0);
        chk({pfx, "_wr"}, bus.o_wrdata, 0);
        chk({pfx, "_din"}, bus.o_bram_din2mlp_din, 0);
    endtask

    // One transaction: start, load, wait, compute, drain; optional reset
    // injected rst_off cycles into the compute window.
    task automatic run_txn(input int r, input int vmode, input bit noise,
                           input int rst_off);
        logic [127:0]    words [NW];
        logic [NROW_W:0] e_addr;
        int nacc, cs, cnt, done_c, last_rd, lim;
        bit cs_k, vdrv, hit, e_ready, e_rden, e_read, e_done, e_busy;
        for (int k = 0; k < NW; k++) begin
            if (vmode == 0 && !noise) words[k] = {16{8'(k)}};
            else words[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        nacc = 0; cs = 0; cs_k = 0; cnt = 0; done_c = -1;
        last_rd = 0; hit = 0;
        lim = 200 + 6 * r;
        for (int c = 0; c < lim; c++) begin
            @(posedge clk);
            #1;
            if (vmode == 0)      vdrv = 1'b1;
            else if (vmode == 1) vdrv = c[0];
            else                 vdrv = 1'($urandom_range(0, 1));
            bus.i_start = (c == 0) ||
                (noise && (c == 3 || (cs_k && r > 0 && c == cs + 1)));
            bus.i_num_rows = (c == 0) ? NROW_W'(r) : NROW_W'($urandom);
            bus.i_vec_valid = vdrv;
            bus.i_vec_data = (vdrv && nacc < NW) ? words[nacc] :
                {$urandom, $urandom, $urandom, $urandom};
            bus.i_mlp_valid = 1'($urandom_range(0, 1));
            if (rst_off >= 0 && cs_k && c == cs + rst_off) begin
                rst = 1'b1;
                hit = 1'b1;
            end
            @(negedge clk);
            if (hit) begin
                chk_reset_outs("midrst");
                m_wr = '0; m_din = '0;
                m_pause = 1'b1; m_first = 1'b0; m_last = 1'b0;
                break;
            end
            e_ready = (c >= 1) && (nacc < NW);
            e_rden  = cs_k && c >= cs && c < cs + 2 * r;
            e_addr  = e_rden ? (NROW_W + 1)'(c - cs) : '0;
            e_read  = cs_k && r > 0 && c >= cs + LAT && c < cs + LAT + 2 * r;
            e_done  = done_c < 0 && cs_k && c >= cs && c >= last_rd && cnt >= r;
            if (e_done) done_c = c;
            e_busy = (c >= 1) && (done_c < 0 || c <= done_c);
            chk("ready", bus.o_vec_ready, e_ready);
            chk("pause", bus.o_pause, m_pause);
            chk("first", bus.o_first, m_first);
            chk("last", bus.o_last, m_last);
            chk("wrdata", bus.o_wrdata, m_wr);
            chk("din", bus.o_bram_din2mlp_din, m_din);
            chk("rden", bus.o_bram_rden, e_rden);
            chk("rdaddr", bus.o_bram_rdaddr, e_addr);
            chk("read", bus.o_read, e_read);
            chk("busy", bus.o_busy, e_busy);
            chk("done", bus.o_done, e_done);
            if (cs_k && c >= cs && cnt < r && bus.i_mlp_valid) cnt++;
            if (e_ready && bus.i_vec_valid) begin
                m_wr    = words[nacc][63:0];
                m_din   = words[nacc][127:64];
                m_first = (nacc == 0);
                m_last  = (nacc == NW - 1);
                m_pause = 1'b0;
                nacc++;
                if (nacc == NW) begin
                    cs_k    = 1'b1;
                    cs      = c + M + 4;
                    last_rd = (r > 0) ? cs + LAT + 2 * r - 1 : cs;
                end
            end else begin
                m_pause = 1'b1;
                m_first = 1'b0;
                m_last  = 1'b0;
            end
            if (done_c >= 0 && c == done_c + 2) break;
        end
        if (!hit) chk("done_seen", done_c >= 0, 1);
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_num_rows  = '0;
        bus.i_vec_data  = '0;
        bus.i_vec_valid = 1'b0;
        bus.i_mlp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        run_txn(3, 0, 1'b0, -1);
        run_txn(4, 1, 1'b0, -1);
        run_txn(0, 0, 1'b0, -1);
        run_txn(2, 2, 1'b1, -1);
        run_txn(5, 0, 1'b0, 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_start = 1'b0;
        bus.i_vec_valid = 1'b0;
        run_txn(3, 2, 1'b0, -1);
        run_txn((1 << NROW_W) - 1, 2, 1'b0, -1);
        for (int i = 0; i < 4; i++)
            run_txn($urandom_range(1, 8), $urandom_range(0, 2), 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
